// File: rtl/jt6295_pipe_dec.sv
// Receiving end of the serialized 4-channel OKI ADPCM pipe: per-slot decode with a
// rotating 4-stage channel state register, attenuation, and a 4-slot frame mixer.
module jt6295_pipe_dec #(
  parameter int OUTW = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen4_i,
  input  logic                   slot0_i,
  input  logic                   pipe_en_i,
  input  logic [3:0]             pipe_att_i,
  input  logic [3:0]             pipe_data_i,
  output logic signed [OUTW-1:0] sound_o,
  output logic                   sample_o
);

  localparam logic [10:0] STEP_ROM [49] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,   11'd31,
    11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,   11'd60,   11'd66,
    11'd73,   11'd80,   11'd88,   11'd97,   11'd107,  11'd118,  11'd130,  11'd143,
    11'd157,  11'd173,  11'd190,  11'd209,  11'd230,  11'd253,  11'd279,  11'd307,
    11'd337,  11'd371,  11'd408,  11'd449,  11'd494,  11'd544,  11'd598,  11'd658,
    11'd724,  11'd796,  11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411,
    11'd1552
  };

  function automatic logic [5:0] gain_rom(input logic [3:0] att);
    case (att)
      4'd0:    gain_rom = 6'd32;
      4'd1:    gain_rom = 6'd22;
      4'd2:    gain_rom = 6'd16;
      4'd3:    gain_rom = 6'd11;
      4'd4:    gain_rom = 6'd8;
      4'd5:    gain_rom = 6'd6;
      4'd6:    gain_rom = 6'd4;
      4'd7:    gain_rom = 6'd3;
      4'd8:    gain_rom = 6'd2;
      default: gain_rom = 6'd0;
    endcase
  endfunction

  // Stage 0 is the head: the channel whose pipe word is on the inputs right now.
  logic signed [11:0] sig_q [4];
  logic        [5:0]  idx_q [4];

  logic        [1:0]      slot_q, slot_d;
  logic                   sync_q, sync_d;
  logic signed [11:0]     scaled_q, scaled_d;
  logic signed [OUTW-1:0] acc_q, sound_q;
  logic                   sample_q;

  logic        [11:0]     step, diff;
  logic signed [13:0]     sig_ext, diff_ext, sig_sum;
  logic signed [7:0]      idx_delta, idx_sum;
  logic signed [11:0]     sig_d;
  logic        [5:0]      idx_d;
  logic        [5:0]      gain;
  logic signed [16:0]     prod;
  logic signed [OUTW-1:0] term_ext, mix_sum;

  always_comb begin
    step     = {1'b0, STEP_ROM[idx_q[0]]};
    diff     = (step >> 3)
             + (pipe_data_i[0] ? (step >> 2) : 12'd0)
             + (pipe_data_i[1] ? (step >> 1) : 12'd0)
             + (pipe_data_i[2] ? step        : 12'd0);
    sig_ext  = {{2{sig_q[0][11]}}, sig_q[0]};
    diff_ext = $signed({2'b00, diff});
    sig_sum  = pipe_data_i[3] ? (sig_ext - diff_ext) : (sig_ext + diff_ext);

    case (pipe_data_i[2:0])
      3'd4:    idx_delta = 8'sd2;
      3'd5:    idx_delta = 8'sd4;
      3'd6:    idx_delta = 8'sd6;
      3'd7:    idx_delta = 8'sd8;
      default: idx_delta = -8'sd1;
    endcase
    idx_sum = $signed({2'b00, idx_q[0]}) + idx_delta;

    if (sig_sum > 14'sd2047)       sig_d = 12'sd2047;
    else if (sig_sum < -14'sd2048) sig_d = -12'sd2048;
    else                           sig_d = sig_sum[11:0];

    if (idx_sum < 8'sd0)       idx_d = 6'd0;
    else if (idx_sum > 8'sd48) idx_d = 6'd48;
    else                       idx_d = idx_sum[5:0];

    // An idle channel is written back clean so it restarts from zero when re-enabled.
    if (!pipe_en_i) begin
      sig_d = 12'sd0;
      idx_d = 6'd0;
    end

    gain     = gain_rom(pipe_att_i);
    prod     = $signed({{5{sig_d[11]}}, sig_d}) * $signed({11'd0, gain});
    scaled_d = 12'(prod >>> 5);

    slot_d   = slot0_i ? 2'd0 : slot_q + 2'd1;
    sync_d   = slot0_i | sync_q;
    term_ext = {{(OUTW-12){scaled_q[11]}}, scaled_q};
    mix_sum  = acc_q + term_ext;
  end

  // slot_q/sync_q describe the word now held in scaled_q; sync gates samples until a
  // frame has started with slot0 since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q    <= '{default: '0};
      idx_q    <= '{default: '0};
      slot_q   <= 2'd0;
      sync_q   <= 1'b0;
      scaled_q <= '0;
      acc_q    <= '0;
      sound_q  <= '0;
      sample_q <= 1'b0;
    end else begin
      sample_q <= 1'b0;
      if (cen4_i) begin
        sig_q[0] <= sig_q[1];
        sig_q[1] <= sig_q[2];
        sig_q[2] <= sig_q[3];
        sig_q[3] <= sig_d;
        idx_q[0] <= idx_q[1];
        idx_q[1] <= idx_q[2];
        idx_q[2] <= idx_q[3];
        idx_q[3] <= idx_d;
        slot_q   <= slot_d;
        sync_q   <= sync_d;
        scaled_q <= scaled_d;
        acc_q    <= (slot_q == 2'd0) ? term_ext : mix_sum;
        if (slot_q == 2'd3 && sync_q) begin
          sound_q  <= mix_sum;
          sample_q <= 1'b1;
        end
      end
    end
  end

  assign sound_o  = sound_q;
  assign sample_o = sample_q;

endmodule
